// File: rtl/ptp_ts_set_arb_pkg.sv
// rtl/ptp_ts_set_arb_pkg.sv - shared types and width helpers for the PTP time-set arbiter
// Purpose : state encoding and width helpers used by ptp_ts_set_arb and its selector.
// Contents: state_t (IDLE, ISSUE, HOLDOFF), id_width(), cnt_width().
package ptp_ts_set_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   // Requester index width; a single port still needs a 1-bit id.
   function automatic int id_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

   // Holdoff counter width; HOLDOFF_CYCLES == 0 still gets a 1-bit counter.
   function automatic int cnt_width(input int holdoff);
      return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
   endfunction

endpackage

// File: rtl/ptp_ts_set_arb_rr.sv
// rtl/ptp_ts_set_arb_rr.sv - combinational round-robin selector
// Purpose : picks the first requesting port after the pointer, wrapping around.
// Ports   : i_req   request vector
//           i_ptr   index of the last granted port
//           o_grant one-hot grant (zero when nothing requests)
//           o_idx   encoded index of the granted port
//           o_any   any request present
module ptp_ts_set_arb_rr #(
   parameter int PORTS = 4,
   parameter int IDW   = 2
) (
   input  logic [PORTS-1:0] i_req,
   input  logic [IDW-1:0]   i_ptr,
   output logic [PORTS-1:0] o_grant,
   output logic [IDW-1:0]   o_idx,
   output logic             o_any
);

   always_comb begin
      int j;
      j       = 0;
      o_any   = 1'b0;
      o_idx   = '0;
      // Scan ptr+1 .. ptr+PORTS so the last-granted port is checked last.
      for (int i = 1; i <= PORTS; i++) begin
         j = (int'(i_ptr) + i) % PORTS;
         if (!o_any && i_req[IDW'(j)]) begin
            o_any = 1'b1;
            o_idx = IDW'(j);
         end
      end
      o_grant = o_any ? (PORTS'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/ptp_ts_set_arb.sv
// rtl/ptp_ts_set_arb.sv - arbitrates timestamp-set requests onto one PTP clock set port
// Purpose : grants one requester at a time, issues a single-cycle load strobe, then
//           blocks further sets for HOLDOFF_CYCLES so downstream CDC logic can relock.
// Option  : PTP_TS_SET_ARB_PRIO_EN gives port 0 strict priority; others stay round-robin.
// Ports   : i_clk, i_rst (async, active-high)
//           i_s_ts[PORTS*TS_WIDTH], i_s_valid[PORTS], o_s_ready[PORTS] - requester side
//           o_m_ts, o_m_ts_valid, o_m_id - clock set port; o_busy high in ISSUE/HOLDOFF
module ptp_ts_set_arb
   import ptp_ts_set_arb_pkg::*;
#(
   parameter int PORTS          = 4,
   parameter int TS_WIDTH       = 96,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [PORTS*TS_WIDTH-1:0] i_s_ts,
   input  logic [PORTS-1:0]          i_s_valid,
   output logic [PORTS-1:0]          o_s_ready,
   output logic [TS_WIDTH-1:0]       o_m_ts,
   output logic                      o_m_ts_valid,
   output logic [id_width(PORTS)-1:0] o_m_id,
   output logic                      o_busy
);

   localparam int IDW = id_width(PORTS);
   localparam int CW  = cnt_width(HOLDOFF_CYCLES);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [IDW-1:0]   r_ptr;

   logic [PORTS-1:0] w_rr_req;
   logic [PORTS-1:0] w_rr_grant;
   logic [IDW-1:0]   w_rr_idx;
   logic             w_rr_any;
   logic [PORTS-1:0] w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_xfer;
   logic [TS_WIDTH-1:0] w_sel_ts;

   ptp_ts_set_arb_rr #(
      .PORTS (PORTS),
      .IDW   (IDW)
   ) u_rr (
      .i_req   (w_rr_req),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

`ifdef PTP_TS_SET_ARB_PRIO_EN
   always_comb begin
      w_rr_req    = i_s_valid;
      w_rr_req[0] = 1'b0;
      if (i_s_valid[0]) begin
         w_grant = PORTS'(1);
         w_idx   = '0;
      end else begin
         w_grant = w_rr_grant;
         w_idx   = w_rr_idx;
      end
   end
`else
   always_comb begin
      w_rr_req = i_s_valid;
      w_grant  = w_rr_grant;
      w_idx    = w_rr_idx;
   end
`endif

   // Ready is gated by reset so nothing is accepted while the block is held in reset.
   assign o_s_ready    = (r_state == IDLE && !i_rst) ? w_grant : '0;
   assign w_xfer       = |o_s_ready;
   assign o_m_ts_valid = (r_state == ISSUE);
   assign o_busy       = (r_state != IDLE);
   assign w_sel_ts     = TS_WIDTH'(i_s_ts >> (int'(w_idx) * TS_WIDTH));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_xfer) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            if (HOLDOFF_CYCLES == 0) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = HOLDOFF;
               w_cnt_nxt   = CW'(HOLDOFF_CYCLES);
            end
         end
         HOLDOFF: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Pointer starts at the last port so port 0 is first in line after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr  <= IDW'(PORTS - 1);
         o_m_ts <= '0;
         o_m_id <= '0;
      end else if (w_xfer) begin
         o_m_ts <= w_sel_ts;
         o_m_id <= w_idx;
`ifdef PTP_TS_SET_ARB_PRIO_EN
         if (w_idx != '0) r_ptr <= w_idx;
`else
         r_ptr <= w_idx;
`endif
      end
   end

endmodule

// File: tb/tb_ptp_ts_set_arb.sv
// tb/tb_ptp_ts_set_arb.sv - self-checking bench for ptp_ts_set_arb
module tb_ptp_ts_set_arb;

   localparam int P  = 4;
   localparam int TW = 96;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [P*TW-1:0] s_ts;
   logic [P-1:0]  s_valid;
   logic [P-1:0]  s_ready;
   logic [TW-1:0] m_ts;
   logic          m_ts_valid;
   logic [1:0]    m_id;
   logic          busy;

   logic [P*TW-1:0] z_ts;
   logic [P-1:0]  z_valid;
   logic [P-1:0]  z_ready;
   logic [TW-1:0] z_m_ts;
   logic          z_m_ts_valid;
   logic [1:0]    z_m_id;
   logic          z_busy;

   typedef struct packed {
      logic [1:0]    id;
      logic [TW-1:0] ts;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pulse  = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ptp_ts_set_arb #(.PORTS(P), .TS_WIDTH(TW), .HOLDOFF_CYCLES(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_s_ts(s_ts), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .o_m_ts(m_ts), .o_m_ts_valid(m_ts_valid), .o_m_id(m_id), .o_busy(busy)
   );

   ptp_ts_set_arb #(.PORTS(P), .TS_WIDTH(TW), .HOLDOFF_CYCLES(0)) dut_z (
      .i_clk(clk), .i_rst(rst), .i_s_ts(z_ts), .i_s_valid(z_valid), .o_s_ready(z_ready),
      .o_m_ts(z_m_ts), .o_m_ts_valid(z_m_ts_valid), .o_m_id(z_m_id), .o_busy(z_busy)
   );

   // Scoreboard: every load strobe must match the oldest expected set.
   always @(negedge clk) begin
      if (m_ts_valid === 1'b1) begin
         n_pulse++;
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got id=%0d ts=%h, expected no strobe", m_id, m_ts);
         end else begin
            mon_e = q.pop_front();
            if (m_id !== mon_e.id || m_ts !== mon_e.ts) begin
               n_fail++;
               $display("FAIL strobe_data: got id=%0d ts=%h, expected id=%0d ts=%h",
                        m_id, m_ts, mon_e.id, mon_e.ts);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [TW-1:0] ts_of(input int p, input int tag);
      return {32'(p + 1), 32'hA5A5_0000, 32'(tag)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ts(input int p, input logic [TW-1:0] v);
      s_ts[p*TW +: TW] = v;
   endtask

   task automatic push(input int p, input logic [TW-1:0] v);
      exp_t e;
      e.id = 2'(p);
      e.ts = v;
      q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy === 1'b0) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy stuck at %b, expected 0 within 100 cycles", busy);
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = '1; s_ts = '0; z_valid = '0; z_ts = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_s_ready: got %b, expected 0000", s_ready); end
      n_checks++;
      if (m_ts !== '0) begin n_fail++; $display("FAIL reset_m_ts: got %h, expected 0", m_ts); end
      n_checks++;
      if (m_ts_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_ts_valid: got %b, expected 0", m_ts_valid); end
      n_checks++;
      if (m_id !== 2'd0) begin n_fail++; $display("FAIL reset_m_id: got %0d, expected 0", m_id); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tick();
      rst = 1'b0; s_valid = '0;
   endtask

   task automatic test_single();
      logic [TW-1:0] t1, t2;
      t1 = 96'h0000_0001_0000_0000_0000_0005;
      t2 = ts_of(2, 1);
      tick();
      set_ts(2, t1); s_valid = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_accept: got %b, expected 0100", s_ready); end
      push(2, t1);
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 1) set_ts(2, t2);
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b1 || s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_holdoff: cycle T+%0d got busy=%b ready=%b, expected busy=1 ready=0000", k, busy, s_ready);
         end
         n_checks++;
         if (m_ts_valid !== (k == 1)) begin
            n_fail++;
            $display("FAIL single_strobe: cycle T+%0d got %b, expected %b", k, m_ts_valid, k == 1);
         end
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || s_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_reaccept: T+18 got busy=%b ready=%b, expected busy=0 ready=0100", busy, s_ready);
      end
      push(2, t2);
      tick();
      s_valid = '0;
      wait_idle();
   endtask

   task automatic test_simultaneous();
      int order[5];
      int last;
      bit found;
      logic [3:0] exp_r;
`ifdef PTP_TS_SET_ARB_PRIO_EN
      order = '{0, 0, 0, 0, 0};
`else
      order = '{0, 1, 2, 3, 0};
`endif
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      for (int p = 0; p < P; p++) set_ts(p, ts_of(p, 7));
      s_valid = 4'b1111;
      last = 0;
      for (int r = 0; r < 5; r++) begin
         found = 1'b0;
         for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (|s_ready) found = 1'b1;
            else tick();
         end
         n_checks++;
         if (!found) begin
            n_fail++;
            $display("FAIL simul_timeout: round %0d got no grant, expected grant within 40 cycles", r);
            break;
         end
         exp_r = 4'b0001 << order[r];
         n_checks++;
         if (s_ready !== exp_r) begin n_fail++; $display("FAIL simul_order: round %0d got %b, expected %b", r, s_ready, exp_r); end
         push(order[r], ts_of(order[r], 7));
         if (r > 0) begin
            n_checks++;
            if (cyc - last !== 18) begin n_fail++; $display("FAIL simul_spacing: round %0d got %0d cycles, expected 18", r, cyc - last); end
         end
         last = cyc;
         tick();
      end
      s_valid = '0;
      wait_idle();
   endtask

   task automatic test_holdoff_block();
      int n0;
      n0 = n_pulse;
      tick();
      set_ts(2, ts_of(2, 9)); s_valid = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL block_first: got %b, expected 0100", s_ready); end
      push(2, ts_of(2, 9));
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 1) s_valid = '0;
         if (k == 4) begin set_ts(1, ts_of(1, 9)); s_valid = 4'b0010; end
         @(negedge clk);
         if (k >= 4) begin
            n_checks++;
            if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL block_hold: T+%0d got %b, expected 0000", k, s_ready); end
         end
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0010) begin n_fail++; $display("FAIL block_grant: got %b, expected 0010", s_ready); end
      push(1, ts_of(1, 9));
      tick();
      s_valid = '0;
      wait_idle();
      n_checks++;
      if (n_pulse - n0 !== 2) begin n_fail++; $display("FAIL block_pulses: got %0d strobes, expected 2", n_pulse - n0); end
   endtask

   task automatic test_reset_mid();
      tick();
      set_ts(1, ts_of(1, 11)); s_valid = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_accept: got %b, expected 0010", s_ready); end
      push(1, ts_of(1, 11));
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) s_valid = '0;
         @(negedge clk);
      end
      tick();
      rst = 1'b1; set_ts(3, ts_of(3, 11)); s_valid = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b0000 || m_ts !== '0 || m_ts_valid !== 1'b0 || m_id !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_outputs: got ready=%b ts=%h v=%b id=%0d busy=%b, expected all 0",
                  s_ready, m_ts, m_ts_valid, m_id, busy);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL rmid_regrant: got %b, expected 1000", s_ready); end
      push(3, ts_of(3, 11));
      tick();
      s_valid = '0;
      wait_idle();
   endtask

   task automatic test_holdoff_zero();
      logic acc;
      tick();
      z_ts[TW-1:0] = ts_of(0, 13); z_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         acc = (k % 2 == 0);
         n_checks++;
         if (z_ready !== {3'b000, acc} || z_m_ts_valid !== !acc || z_busy !== !acc) begin
            n_fail++;
            $display("FAIL zero_pattern: step %0d got ready=%b v=%b busy=%b, expected ready=%b v=%b busy=%b",
                     k, z_ready, z_m_ts_valid, z_busy, {3'b000, acc}, !acc, !acc);
         end
         if (!acc) begin
            n_checks++;
            if (z_m_ts !== ts_of(0, 13) || z_m_id !== 2'd0) begin
               n_fail++;
               $display("FAIL zero_data: got id=%0d ts=%h, expected id=0 ts=%h", z_m_id, z_m_ts, ts_of(0, 13));
            end
         end
         tick();
      end
      z_valid = '0;
   endtask

`ifdef PTP_TS_SET_ARB_PRIO_EN
   task automatic test_prio();
      bit found;
      int ep;
      tick();
      set_ts(0, ts_of(0, 21)); set_ts(2, ts_of(2, 21));
      s_valid = 4'b0101;
      for (int r = 0; r < 4; r++) begin
         ep = (r < 3) ? 0 : 2;
         found = 1'b0;
         for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (|s_ready) found = 1'b1;
            else tick();
         end
         n_checks++;
         if (!found || s_ready !== (4'b0001 << ep)) begin
            n_fail++;
            $display("FAIL prio_grant: round %0d got %b, expected %b", r, s_ready, 4'b0001 << ep);
         end
         push(ep, ts_of(ep, 21));
         tick();
         if (r == 2) s_valid = 4'b0100;
      end
      s_valid = '0;
      wait_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_holdoff_block();
      test_reset_mid();
      test_holdoff_zero();
`ifdef PTP_TS_SET_ARB_PRIO_EN
      test_prio();
`endif
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
